// File: rtl/dac_serializer_12.sv
// rtl/dac_serializer_12.sv - round/saturate filter result to 12-bit offset binary and shift out a 16-bit DAC SPI frame
module dac_serializer_12 #(
    parameter int cant_bits = 25,
    parameter int frac_bits = 16,
    parameter int div_sclk  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic [cant_bits-1:0] y,
    output logic                 sync_n,
    output logic                 sclk,
    output logic                 din,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf,
    output logic                 sat
);
    localparam int sh = frac_bits - 11;
    localparam int hw = $clog2(div_sclk) + 1;
    localparam logic [hw-1:0] half_end = hw'(div_sclk - 1);
    localparam logic [hw-1:0] gap_end  = hw'(2 * div_sclk - 1);
    localparam logic signed [cant_bits:0] rnd_add = $signed((cant_bits + 1)'(1) << (frac_bits - 12));
    localparam logic signed [cant_bits:0] s_max   = (cant_bits + 1)'(2047);
    localparam logic signed [cant_bits:0] s_min   = (cant_bits + 1)'(-2048);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t         state_q, state_d;
    logic [hw-1:0]  hcnt_q, hcnt_d;
    logic [4:0]     bcnt_q, bcnt_d;
    logic [15:0]    shift_q, shift_d;
    logic           sclk_q, sclk_d;
    logic [11:0]    pend_q, pend_d;
    logic           pend_valid_q, pend_valid_d;
    logic           ovf_q, ovf_d;
    logic           sat_q, sat_d;
    logic           done_c;

    logic signed [cant_bits:0] y_wide, y_rnd, s_full;
    logic [11:0]               code;
    logic                      clip;

    // Extra sign bit keeps the rounding add from wrapping at full scale.
    always_comb begin
        y_wide = $signed({y[cant_bits-1], y});
        y_rnd  = y_wide + rnd_add;
        s_full = y_rnd >>> sh;
        clip   = 1'b0;
        code   = {~s_full[11], s_full[10:0]};
        if (s_full > s_max) begin
            code = 12'hFFF;
            clip = 1'b1;
        end else if (s_full < s_min) begin
            code = 12'h000;
            clip = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        hcnt_d       = hcnt_q;
        bcnt_d       = bcnt_q;
        shift_d      = shift_q;
        sclk_d       = sclk_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        ovf_d        = ovf_q;
        sat_d        = sat_q;
        done_c       = 1'b0;

        if (rx) begin
            if (clip) sat_d = 1'b1;
            if (state_q != IDLE) begin
                pend_d       = code;
                pend_valid_d = 1'b1;
                if (pend_valid_q) ovf_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                sclk_d = 1'b1;
                hcnt_d = '0;
                bcnt_d = '0;
                if (rx) begin
                    shift_d = {4'b0000, code};
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                hcnt_d = hcnt_q + 1'b1;
                if (hcnt_q == half_end) begin
                    hcnt_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        bcnt_d = bcnt_q + 1'b1;
                    end else begin
                        sclk_d = 1'b1;
                        if (bcnt_q == 5'd16) begin
                            bcnt_d  = '0;
                            done_c  = 1'b1;
                            state_d = GAP;
                        end else begin
                            shift_d = {shift_q[14:0], 1'b0};
                        end
                    end
                end
            end
            GAP: begin
                hcnt_d = hcnt_q + 1'b1;
                // pend_d already holds a same-cycle rx, so it is served without loss.
                if (hcnt_q == gap_end) begin
                    hcnt_d = '0;
                    if (pend_valid_d) begin
                        shift_d      = {4'b0000, pend_d};
                        pend_valid_d = 1'b0;
                        state_d      = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            hcnt_q       <= '0;
            bcnt_q       <= '0;
            shift_q      <= '0;
            sclk_q       <= 1'b1;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hcnt_q       <= hcnt_d;
            bcnt_q       <= bcnt_d;
            shift_q      <= shift_d;
            sclk_q       <= sclk_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            ovf_q        <= ovf_d;
            sat_q        <= sat_d;
        end
    end

    assign sync_n = (state_q != SHIFT);
    assign din    = (state_q == SHIFT) & shift_q[15];
    assign sclk   = sclk_q;
    assign busy   = (state_q != IDLE);
    assign done   = done_c;
    assign ovf    = ovf_q;
    assign sat    = sat_q;
endmodule

// File: tb/tb_dac_serializer_12.sv
// tb/tb_dac_serializer_12.sv - self-checking bench for dac_serializer_12
module tb_dac_serializer_12;
    localparam int CB = 25;
    localparam int FB = 16;
    localparam int DV = 2;

    logic          clk = 1'b0;
    logic          rst, rx;
    logic [CB-1:0] y;
    logic          sync_n, sclk, din, busy, done, ovf, sat;

    always #5 clk = ~clk;

    dac_serializer_12 #(.cant_bits(CB), .frac_bits(FB), .div_sclk(DV)) dut (
        .clk(clk), .rst(rst), .rx(rx), .y(y),
        .sync_n(sync_n), .sclk(sclk), .din(din), .busy(busy),
        .done(done), .ovf(ovf), .sat(sat)
    );

    typedef struct {int word; int nbits; int low; int dones; int gap;} frame_t;
    typedef struct {int y; int code; int sat;} vec_t;

    frame_t frames[$];
    int checks = 0;
    int errors = 0;

    // Frame observer: records the bits the DAC would latch on each sclk fall.
    int   m_word, m_bits, m_low, m_dones, m_gap_cnt = 999, m_gap_rec;
    logic m_prev_sync = 1'b1, m_prev_sclk = 1'b1;
    always @(negedge clk) begin
        if (sync_n === 1'b0) begin
            if (m_prev_sync) begin
                m_word = 0; m_bits = 0; m_low = 0; m_dones = 0; m_gap_rec = m_gap_cnt;
            end
            m_low++;
            if (done) m_dones++;
            if (m_prev_sclk && !sclk) begin
                m_word = ((m_word << 1) | int'(din)) & 16'hFFFF;
                m_bits++;
            end
        end else begin
            if (!m_prev_sync) begin
                frames.push_back('{m_word, m_bits, m_low, m_dones, m_gap_rec});
                m_gap_cnt = 1;
            end else begin
                m_gap_cnt++;
            end
        end
        m_prev_sync = sync_n;
        m_prev_sclk = sclk;
    end

    function automatic void ref_conv(input int yv, output int code, output int clip);
        longint num, den, q;
        num = longint'(yv) + (longint'(1) << (FB - 12));
        den = longint'(1) << (FB - 11);
        if (num >= 0) q = num / den;
        else          q = -((-num + den - 1) / den);
        clip = 0;
        if (q > 2047)  begin q = 2047;  clip = 1; end
        if (q < -2048) begin q = -2048; clip = 1; end
        code = int'(q) + 2048;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int v);
        y  = CB'(v);
        rx = 1'b1;
        tick(1);
        rx = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 1000) begin
            tick(1);
            n++;
        end
        check("idle_timeout", int'(busy), 0);
    endtask

    task automatic check_frame(input string name, input int exp_word);
        int     n = 0;
        frame_t f;
        while (frames.size() == 0 && n < 1000) begin
            tick(1);
            n++;
        end
        if (frames.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s no frame seen got 0 frames expected 1", name);
        end else begin
            f = frames.pop_front();
            check({name, "_word"}, f.word, exp_word);
            check({name, "_bits"}, f.nbits, 16);
            check({name, "_synclow"}, f.low, 32 * DV);
            check({name, "_done"}, f.dones, 1);
        end
    endtask

    vec_t tbl[8];
    int   y1, y2, c1, c2, k1, k2, sat_exp, drops, off, n;
    frame_t fa, fb;

    initial begin
        tbl[0] = '{0,        'h800, 0};
        tbl[1] = '{32768,    'hC00, 0};
        tbl[2] = '{15,       'h800, 0};
        tbl[3] = '{16,       'h801, 0};
        tbl[4] = '{-17,      'h7FF, 0};
        tbl[5] = '{-65536,   'h000, 0};
        tbl[6] = '{196608,   'hFFF, 1};
        tbl[7] = '{-1000000, 'h000, 1};

        rst = 1'b1; rx = 1'b0; y = '0;
        tick(3);
        rst = 1'b0;
        check("rst_sync_n", int'(sync_n), 1);
        check("rst_sclk", int'(sclk), 1);
        check("rst_din", int'(din), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_sat", int'(sat), 0);

        // Reset in the middle of a frame.
        send(1234);
        tick(19);
        rst = 1'b1;
        tick(1);
        check("midrst_sync_n", int'(sync_n), 1);
        check("midrst_sclk", int'(sclk), 1);
        check("midrst_busy", int'(busy), 0);
        rst = 1'b0;
        tick(2);
        frames.delete();
        send(0);
        check_frame("after_rst", 'h0800);
        check("after_rst_ovf", int'(ovf), 0);

        for (int i = 0; i < 8; i++) begin
            wait_idle();
            send(tbl[i].y);
            check_frame($sformatf("vec%0d", i), tbl[i].code);
            check($sformatf("vec%0d_sat", i), int'(sat), tbl[i].sat);
        end

        // Back-to-back: second sample waits in pending, busy never drops.
        wait_idle();
        send(0);
        tick(8);
        send(32768);
        drops = 0;
        n = 0;
        while (frames.size() < 2 && n < 500) begin
            if (!busy) drops++;
            tick(1);
            n++;
        end
        check("b2b_busy_drops", drops, 0);
        check("b2b_frames", frames.size(), 2);
        if (frames.size() == 2) begin
            fa = frames.pop_front();
            fb = frames.pop_front();
            check("b2b_first", fa.word, 'h0800);
            check("b2b_second", fb.word, 'h0C00);
            check("b2b_gap", fb.gap, 2 * DV);
            check("b2b_low", fb.low, 32 * DV);
        end
        frames.delete();
        check("b2b_ovf", int'(ovf), 0);

        // Randomized pairs: one sample from idle, one arriving mid-frame.
        wait_idle();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        sat_exp = 0;
        for (int i = 0; i < 16; i++) begin
            wait_idle();
            y1  = int'($urandom_range(0, 1 << 20)) - (1 << 19);
            y2  = int'($urandom_range(0, 1 << 20)) - (1 << 19);
            off = int'($urandom_range(1, 55));
            ref_conv(y1, c1, k1);
            ref_conv(y2, c2, k2);
            sat_exp = sat_exp | k1 | k2;
            send(y1);
            tick(off);
            send(y2);
            check_frame($sformatf("rnd%0d_a", i), c1);
            check_frame($sformatf("rnd%0d_b", i), c2);
            check($sformatf("rnd%0d_sat", i), int'(sat), sat_exp);
        end
        wait_idle();
        check("rnd_ovf", int'(ovf), 0);

        // Overwrite: the newest pending sample wins and ovf sticks.
        ref_conv(1000, c1, k1);
        send(1000);
        tick(4);
        send(16);
        tick(4);
        send(32768);
        check_frame("ovw_first", c1);
        check_frame("ovw_second", 'h0C00);
        check("ovw_ovf", int'(ovf), 1);
        wait_idle();
        tick(20);
        check("ovw_no_extra_frame", frames.size(), 0);
        check("ovw_ovf_sticky", int'(ovf), 1);

        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("final_ovf", int'(ovf), 0);
        check("final_sat", int'(sat), 0);
        check("final_sync_n", int'(sync_n), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
